mc_mips_core: RTL

//  Multi-cycle MIPS core: next generation of our single-cycle core, same ISA subset
//  (add/sub/and/or/slt, lw, sw, beq, j, jal, jr), shared ALU, FSM-sequenced.

---
 rtl/mc_mips_pkg.sv | 43 ++++
 rtl/mc_mips_regfile.sv | 60 ++++++
 rtl/mc_mips_core.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct encodings,
// ALU control codes, FSM states and the immediate sign-extension helper.
package mc_mips_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_mips_regfile.sv
// Register file: NUM_REGS x 32, two combinational read ports, one synchronous
// write port, asynchronous reset to zero; r0 is never written and reads as 0.
module mc_mips_regfile
    import mc_mips_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        i_raddr_a,
    input  logic [4:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_wen,
    input  logic [4:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    localparam int unsigned RA_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [RA_W-1:0]   w_ra_a;
    logic [RA_W-1:0]   w_ra_b;
    logic [RA_W-1:0]   w_wa;
    logic [NUM_REGS-1:0] w_we;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    assign w_ra_a = i_raddr_a[RA_W-1:0];
    assign w_ra_b = i_raddr_b[RA_W-1:0];
    assign w_wa   = i_waddr[RA_W-1:0];

    // Per-register write strobes; slot 0 never gets one, which keeps r0 at zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
            if (gi == 0) begin : g_r0
                assign w_we[gi] = 1'b0;
            end else begin : g_rn
                assign w_we[gi] = i_wen && (w_wa == RA_W'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= i_wdata;
                end
            end
        end
    end

    assign o_rdata_a = (w_ra_a == '0) ? '0 : r_regs[w_ra_a];
    assign o_rdata_b = (w_ra_b == '0) ? '0 : r_regs[w_ra_b];

endmodule

// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS core (add/sub/and/or/slt, lw, sw, beq, j, jal, jr) with one shared ALU.
// Optional MC_MIPS_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module mc_mips_core
    import mc_mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       IR_addr,
    input  logic [31:0]       IR,
    input  logic              IR_valid,
    input  logic [31:0]       ReadDataMem,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WriteDataMem,
    output logic [31:0]       RF_writedata,
    output logic              RF_wen,
    output logic              illegal_op
`ifdef MC_MIPS_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_areg;
    logic [31:0] r_breg;
    logic [31:0] r_aluout;
    logic [31:0] r_brtgt;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_sext;
    logic        w_is_r, w_is_ralu, w_is_jr, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_jal, w_legal;

    alu_op_e     w_alu_op;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic        w_alu_zero;

    logic [31:0] w_rd_a;
    logic [31:0] w_rd_b;
    logic        w_rf_wen;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic        w_illegal;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = sext16(r_ir[15:0]);

    assign w_is_r    = (w_op == OP_RTYPE);
    assign w_is_ralu = w_is_r && ((w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                                  (w_funct == FN_OR)  || (w_funct == FN_SLT));
    assign w_is_jr   = w_is_r && (w_funct == FN_JR);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_j    = (w_op == OP_J);
    assign w_is_jal  = (w_op == OP_JAL);
    assign w_legal   = w_is_ralu || w_is_jr || w_is_lw || w_is_sw || w_is_beq || w_is_j || w_is_jal;

    mc_mips_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b),
        .i_wen     (w_rf_wen),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata)
    );

    // The single ALU computes PC+4 in FETCH, the branch target in DECODE and the result in EXEC.
    always_comb begin
        w_alu_a  = r_pc;
        w_alu_b  = 32'd4;
        w_alu_op = ALU_ADD;
        case (r_state)
            S_DECODE: w_alu_b = {w_imm_sext[29:0], 2'b00};
            S_EXEC: begin
                w_alu_a = r_areg;
                if (w_is_r) begin
                    w_alu_b = r_breg;
                    case (w_funct)
                        FN_SUB:  w_alu_op = ALU_SUB;
                        FN_AND:  w_alu_op = ALU_AND;
                        FN_OR:   w_alu_op = ALU_OR;
                        FN_SLT:  w_alu_op = ALU_SLT;
                        default: w_alu_op = ALU_ADD;
                    endcase
                end else if (w_is_beq) begin
                    w_alu_b  = r_breg;
                    w_alu_op = ALU_SUB;
                end else begin
                    w_alu_b = w_imm_sext;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_y = w_alu_a + w_alu_b;
        endcase
    end

    assign w_alu_zero = (w_alu_y == 32'd0);

    // lw goes MEM -> WB directly: SRAM data arrives in WB and is written straight through.
    always_comb begin
        w_state_next = r_state;
        CEN          = 1'b1;
        WEN          = 1'b1;
        w_rf_wen     = 1'b0;
        w_rf_waddr   = 5'd0;
        w_rf_wdata   = 32'd0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (IR_valid) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC: begin
                w_state_next = S_FETCH;
                if (w_is_ralu) begin
                    w_state_next = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_state_next = S_MEM;
                end
                if (w_is_jal) begin
                    w_rf_wen   = 1'b1;
                    w_rf_waddr = REG_RA;
                    w_rf_wdata = r_pc;
                end
                w_illegal = !w_legal;
            end
            S_MEM: begin
                CEN = 1'b0;
                if (w_is_sw) begin
                    WEN          = 1'b0;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_state_next = S_FETCH;
                w_rf_wen     = 1'b1;
                if (w_is_lw) begin
                    w_rf_waddr = w_rt;
                    w_rf_wdata = ReadDataMem;
                end else begin
                    w_rf_waddr = w_rd;
                    w_rf_wdata = r_aluout;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= 32'd0;
            r_areg   <= 32'd0;
            r_breg   <= 32'd0;
            r_aluout <= 32'd0;
            r_brtgt  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_FETCH: begin
                    if (IR_valid) begin
                        r_ir <= IR;
                        r_pc <= w_alu_y;
                    end
                end
                S_DECODE: begin
                    r_areg  <= w_rd_a;
                    r_breg  <= w_rd_b;
                    r_brtgt <= w_alu_y;
                end
                S_EXEC: begin
                    if (w_is_ralu || w_is_lw || w_is_sw) begin
                        r_aluout <= w_alu_y;
                    end
                    if (w_is_beq && w_alu_zero) begin
                        r_pc <= r_brtgt;
                    end
                    if (w_is_j || w_is_jal) begin
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    end
                    if (w_is_jr) begin
                        r_pc <= r_areg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IR_addr      = r_pc;
    assign OEN          = 1'b0;
    assign A            = r_aluout[ADDR_W+1:2];
    assign WriteDataMem = r_breg;
    assign RF_wen       = w_rf_wen;
    assign RF_writedata = w_rf_wdata;
    assign illegal_op   = w_illegal;

`ifdef MC_MIPS_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if ((r_state == S_FETCH) && IR_valid) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule
